data_pipe_dispatch: RTL

One-to-eight pipelined dispatcher for the `data_inf` valid/ready stream. A single upstream slave port feeds one of eight downstream master ports, chosen by `sw`, through a two-entry skid buffer that sustains one transfer per clock with a fully registered upstream ready. It sits where one producer, such as an I2C read-data path, must be steered to one of several consumers. It is the counterpart of the eight-to-one pipe interconnect.

---
 rtl/data_pipe_dispatch.sv | 121 ++++++++++++
 1 files changed

// File: rtl/data_pipe_dispatch.sv
// One-to-eight valid/ready dispatcher: a two-entry skid buffer feeds the master
// selected by sw, with a registered upstream ready and a path latched only while empty.
module data_pipe_dispatch #(
    parameter int DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             vld_sw,
    input  logic [2:0]       sw,
    output logic [2:0]       curr_path,
    output logic             busy,
    input  logic             s00_valid,
    input  logic [DSIZE-1:0] s00_data,
    output logic             s00_ready,
    output logic             m00_valid,
    output logic [DSIZE-1:0] m00_data,
    input  logic             m00_ready,
    output logic             m01_valid,
    output logic [DSIZE-1:0] m01_data,
    input  logic             m01_ready,
    output logic             m02_valid,
    output logic [DSIZE-1:0] m02_data,
    input  logic             m02_ready,
    output logic             m03_valid,
    output logic [DSIZE-1:0] m03_data,
    input  logic             m03_ready,
    output logic             m04_valid,
    output logic [DSIZE-1:0] m04_data,
    input  logic             m04_ready,
    output logic             m05_valid,
    output logic [DSIZE-1:0] m05_data,
    input  logic             m05_ready,
    output logic             m06_valid,
    output logic [DSIZE-1:0] m06_data,
    input  logic             m06_ready,
    output logic             m07_valid,
    output logic [DSIZE-1:0] m07_data,
    input  logic             m07_ready
);

    typedef enum logic [1:0] {IDLE, EMPTY, ONE, TWO} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DSIZE-1:0] main_reg;
    logic [DSIZE-1:0] skid_reg;
    logic             ready_reg;
    logic [2:0]       path_reg;
    logic             accept;
    logic             deliver;
    logic [7:0]       ready_vec;
    logic [7:0]       valid_vec;

    assign ready_vec = {m07_ready, m06_ready, m05_ready, m04_ready,
                        m03_ready, m02_ready, m01_ready, m00_ready};

    assign busy    = (state == ONE) || (state == TWO);
    assign accept  = s00_valid & ready_reg & clk_en;
    assign deliver = busy & ready_vec[path_reg] & clk_en;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clk_en) state_nxt = EMPTY;
            EMPTY:   if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !deliver)
                    state_nxt = TWO;
                else if (deliver && !accept)
                    state_nxt = EMPTY;
            end
            TWO:     if (deliver) state_nxt = ONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is precomputed for the next state so it can be a plain flop; while
    // disabled it may only drop, never rise.
    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            main_reg  <= '0;
            skid_reg  <= '0;
            ready_reg <= 1'b0;
            path_reg  <= 3'd0;
        end else begin
            state <= state_nxt;
            if (clk_en) begin
                ready_reg <= (state_nxt == EMPTY || state_nxt == ONE) ? vld_sw : 1'b0;
                if (state_nxt == EMPTY)
                    path_reg <= sw;
            end else begin
                ready_reg <= ready_reg & vld_sw;
            end
            if (accept && (state == EMPTY || deliver))
                main_reg <= s00_data;
            else if (accept)
                skid_reg <= s00_data;
            else if (state == TWO && deliver)
                main_reg <= skid_reg;
        end
    end

    assign valid_vec = busy ? (8'd1 << path_reg) : 8'd0;
    assign curr_path = path_reg;
    assign s00_ready = ready_reg;

    assign {m07_valid, m06_valid, m05_valid, m04_valid,
            m03_valid, m02_valid, m01_valid, m00_valid} = valid_vec;

    assign m00_data = main_reg;
    assign m01_data = main_reg;
    assign m02_data = main_reg;
    assign m03_data = main_reg;
    assign m04_data = main_reg;
    assign m05_data = main_reg;
    assign m06_data = main_reg;
    assign m07_data = main_reg;

endmodule
